v_debounce_pulse: RTL
=====================

V_DEBOUNCE_PULSE -- requirements
Module: v_debounce_pulse

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 8, number of consecutive stable synchronized samples needed to accept a level change; legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 4, debounce counter width; SHALL hold 2**CNT_W >= DB_CYCLES.
REQ-003 SHALL have port C  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port CLR_N  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port D  input  1  raw asynchronous input (switch or external event).
REQ-006 SHALL have port EN  input  1  pulse enable; gates CE only.
REQ-007 SHALL have port CE  output  1  one-cycle count-enable pulse on each accepted 0->1 transition; drives the clock-enable input of the downstream counter.
REQ-008 SHALL have port LVL  output  1  debounced level of D.
REQ-009 SHALL have port BUSY  output  1  high while a candidate transition is being qualified.

Function
REQ-010 SHALL pass D through a two-flop synchronizer (s1, s2) before any other logic uses it.
REQ-011 SHALL implement a 4-state FSM: LOW (stable 0), ARM_HI (qualifying 1), HIGH (stable 1), ARM_LO (qualifying 0).
REQ-012 LOW: s2=1 -> ARM_HI with cnt=0; otherwise hold.
REQ-013 ARM_HI: s2=0 -> LOW with cnt=0 (glitch rejected, no CE); s2=1 and cnt=DB_CYCLES-1 -> HIGH; otherwise cnt=cnt+1.
REQ-014 HIGH: s2=0 -> ARM_LO with cnt=0; otherwise hold.
REQ-015 ARM_LO: s2=1 -> HIGH with cnt=0; s2=0 and cnt=DB_CYCLES-1 -> LOW; otherwise cnt=cnt+1.
REQ-016 CE SHALL be registered and high for exactly one cycle, in the cycle after the ARM_HI->HIGH transition, and only if EN=1 at that edge.
REQ-017 With EN=0 at the ARM_HI->HIGH edge, the pulse SHALL be discarded, not deferred; the FSM and LVL SHALL be unaffected by EN.
REQ-018 Latency: for D held high from before rising edge 1, CE SHALL be high in the cycle following rising edge DB_CYCLES+3.
REQ-019 LVL SHALL be 1 in HIGH and ARM_LO, and 0 in LOW and ARM_HI, registered, so it changes in the same cycle as CE.
REQ-020 BUSY SHALL equal (state==ARM_HI or state==ARM_LO).
REQ-021 cnt SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-022 Consecutive CE pulses SHALL be separated by at least 2*DB_CYCLES+2 cycles.
REQ-023 The falling (release) transition SHALL never generate CE.

Reset
REQ-024 CLR_N=0 SHALL immediately force s1=0, s2=0, state=LOW, cnt=0, CE=0, LVL=0 and BUSY=0, regardless of C.
REQ-025 Reset asserted mid-qualification SHALL abandon the candidate transition; after release, a still-high D SHALL be requalified from LOW with full latency.
REQ-026 Reset release SHALL take effect on the first rising edge of C at which CLR_N=1.

Structure
REQ-027 SHALL instantiate one sub-module v_sync2 (two-flop synchronizer with the same C/CLR_N reset), which is reusable by other blocks.
REQ-028 State encodings SHALL be localparams within the module; no shared package or include file is required.
REQ-029 Output registers SHALL feed CE, LVL and BUSY directly, with no combinational path from D.

Verification (DB_CYCLES=8)
REQ-030 Reset, then D=1 held: CE=1 for exactly one cycle after edge 11, LVL=1 in the same cycle, and BUSY high for 8 cycles before that.
REQ-031 D=1 for 5 cycles then 0: no CE, LVL stays 0, and the FSM returns to LOW.
REQ-032 Press of 20 cycles, release of 20 cycles, repeated 3 times into v_counters_5 with CE wired: counter Q=3.
REQ-033 EN=0 during an accepted press: CE stays 0 and LVL=1; EN raised while still in HIGH: still no CE.
REQ-034 CLR_N pulsed low at cnt=4 in ARM_HI while D stays 1: outputs go to 0 asynchronously, and CE occurs 11 edges after reset release.
REQ-035 Bounce of alternating 1/0 every 3 cycles for 50 cycles, then stable 1: exactly one CE.

Source files
------------

// File: rtl/v_debounce_pulse_pkg.sv
// Shared types and limits for the debounce/pulse block.
// Used by the top-level debouncer and reusable by neighbouring blocks.
package v_debounce_pulse_pkg;

  localparam int DB_CYCLES_MIN = 2;
  localparam int DB_CYCLES_MAX = 16;

  // Registered outputs travel together so they always change on the same edge.
  typedef struct packed {
    logic ce;
    logic lvl;
    logic busy;
  } dbp_out_t;

  localparam dbp_out_t DBP_OUT_RESET = '{ce: 1'b0, lvl: 1'b0, busy: 1'b0};

  // True when the parameter pair is usable: DB_CYCLES in range, and the
  // counter wide enough to hold DB_CYCLES-1.
  function automatic bit params_legal(input int db_cycles, input int cnt_w);
    return (db_cycles >= DB_CYCLES_MIN) && (db_cycles <= DB_CYCLES_MAX) &&
           ((1 << cnt_w) >= db_cycles);
  endfunction

endpackage

// File: rtl/v_sync2.sv
// Two-flop synchronizer for one asynchronous input bit.
// The reset clears both stages, so the output reads 0 until two edges after release.
module v_sync2 (
  input  logic C,
  input  logic CLR_N,
  input  logic D,
  output logic Q
);

  logic s1;
  logic s2;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs from before the edge; blocking would collapse the chain.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= D;
      s2 <= s1;
    end
  end

  assign Q = s2;

endmodule

// File: rtl/v_debounce_pulse.sv
// Debounces a raw input and emits a one-cycle count-enable on each accepted press.
// All outputs come straight from registers; D only reaches logic through v_sync2.
module v_debounce_pulse
  import v_debounce_pulse_pkg::*;
#(
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic C,
  input  logic CLR_N,
  input  logic D,
  input  logic EN,
  output logic CE,
  output logic LVL,
  output logic BUSY
);

  localparam logic [1:0] ST_LOW    = 2'd0;
  localparam logic [1:0] ST_ARM_HI = 2'd1;
  localparam logic [1:0] ST_HIGH   = 2'd2;
  localparam logic [1:0] ST_ARM_LO = 2'd3;

  typedef enum logic [1:0] {
    S_LOW    = ST_LOW,
    S_ARM_HI = ST_ARM_HI,
    S_HIGH   = ST_HIGH,
    S_ARM_LO = ST_ARM_LO
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s2;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dbp_out_t         out_q, out_d;

  v_sync2 u_sync (
    .C     (C),
    .CLR_N (CLR_N),
    .D     (D),
    .Q     (s2)
  );

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      out_q   <= DBP_OUT_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_LOW: begin
        if (s2) begin
          state_d = S_ARM_HI;
          cnt_d   = '0;
        end
      end
      S_ARM_HI: begin
        if (!s2) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!s2) begin
          state_d = S_ARM_LO;
          cnt_d   = '0;
        end
      end
      S_ARM_LO: begin
        if (s2) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so LVL, BUSY and CE all move
  // on the edge that accepts the transition; a press masked by EN is dropped.
  always_comb begin
    out_d      = DBP_OUT_RESET;
    out_d.ce   = (state_q == S_ARM_HI) && (state_d == S_HIGH) && EN;
    out_d.lvl  = (state_d == S_HIGH) || (state_d == S_ARM_LO);
    out_d.busy = (state_d == S_ARM_HI) || (state_d == S_ARM_LO);
  end

  assign CE   = out_q.ce;
  assign LVL  = out_q.lvl;
  assign BUSY = out_q.busy;

endmodule
